board_receiver: RTL and testbench

- Receive-side counterpart of the solver's board transmitter. Consumes the PC-link byte stream (UART RX side) and decodes 16-bit board messages.
- Reconstructs board dimensions m, n and the cell bitmap in the solver's MAX_COLS-strided layout.
- Presents the completed board with a one-cycle valid pulse. Flags protocol violations with a one-cycle error pulse.

---
 rtl/board_receiver.sv | 187 ++++++++++++++++++
 tb/tb_board_receiver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/board_receiver.sv
// Receive-side board decoder: pairs PC-link bytes into 16-bit messages and
// rebuilds the board bitmap (MAX_COLS-strided), dimensions and error/valid pulses.
module board_receiver #(
  parameter int unsigned MAX_ROWS = 11,
  parameter int unsigned MAX_COLS = 11
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                valid_in,
  input  logic [7:0]                          byte_in,
  output logic [MAX_ROWS*MAX_COLS-1:0]        board,
  output logic [$clog2(MAX_ROWS)-1:0]         m,
  output logic [$clog2(MAX_COLS)-1:0]         n,
  output logic                                valid_out,
  output logic                                error,
  output logic                                busy
);

  localparam int unsigned CELLS = MAX_ROWS * MAX_COLS;
  localparam int unsigned MW    = $clog2(MAX_ROWS);
  localparam int unsigned NW    = $clog2(MAX_COLS);
  localparam int unsigned RW    = $clog2(MAX_ROWS + 1);
  localparam int unsigned CW    = $clog2(MAX_COLS + 1);
  localparam int unsigned BW    = $clog2(CELLS + 1);
  localparam int unsigned IW    = 12;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GET_N    = 2'd1;
  localparam logic [1:0] ASSIGN   = 2'd2;
  localparam logic [1:0] WAIT_END = 2'd3;

  localparam logic [2:0] FLAG_START = 3'b111;
  localparam logic [2:0] FLAG_AND   = 3'b101;
  localparam logic [2:0] FLAG_END   = 3'b000;

  logic [1:0]       state, state_d;
  logic             phase, phase_d;
  logic [7:0]       lo_byte, lo_byte_d;
  logic [IW-1:0]    wm, wm_d, wn, wn_d, expected, expected_d;
  logic [RW-1:0]    row, row_d;
  logic [CW-1:0]    col, col_d;
  logic [BW-1:0]    row_base, row_base_d;
  logic [CELLS-1:0] wbits, wbits_d;
  logic [CELLS-1:0] board_d;
  logic [MW-1:0]    m_d;
  logic [NW-1:0]    n_d;
  logic             valid_d, error_d;

  logic [15:0]      word;
  logic [2:0]       flag;
  logic [IW-1:0]    idx;
  logic             val;
  logic             hi_accept;
  logic [BW-1:0]    cell_idx;
  logic             last_cell;

  assign word      = {byte_in, lo_byte};
  assign flag      = word[15:13];
  assign idx       = word[12:1];
  assign val       = word[0];
  assign hi_accept = valid_in && phase;
  assign cell_idx  = row_base + BW'(col);
  assign last_cell = (IW'(row) == wm - IW'(1)) && (IW'(col) == wn - IW'(1));

  // Derived purely from flops: in a message or holding a low byte
  assign busy = (state != IDLE) || phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= 1'b0;
      lo_byte   <= '0;
      wm        <= '0;
      wn        <= '0;
      expected  <= '0;
      row       <= '0;
      col       <= '0;
      row_base  <= '0;
      wbits     <= '0;
      board     <= '0;
      m         <= '0;
      n         <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_d;
      phase     <= phase_d;
      lo_byte   <= lo_byte_d;
      wm        <= wm_d;
      wn        <= wn_d;
      expected  <= expected_d;
      row       <= row_d;
      col       <= col_d;
      row_base  <= row_base_d;
      wbits     <= wbits_d;
      board     <= board_d;
      m         <= m_d;
      n         <= n_d;
      valid_out <= valid_d;
      error     <= error_d;
    end
  end

  // Next-state and working-register update; decode only on the high byte
  always_comb begin
    state_d    = state;
    phase_d    = phase;
    lo_byte_d  = lo_byte;
    wm_d       = wm;
    wn_d       = wn;
    expected_d = expected;
    row_d      = row;
    col_d      = col;
    row_base_d = row_base;
    wbits_d    = wbits;
    board_d    = board;
    m_d        = m;
    n_d        = n;
    valid_d    = 1'b0;
    error_d    = 1'b0;

    if (valid_in) begin
      phase_d = ~phase;
      if (!phase) lo_byte_d = byte_in;
    end

    if (hi_accept) begin
      case (state)
        IDLE: begin
          if (flag == FLAG_START) begin
            wm_d    = idx;
            wbits_d = '0;
            state_d = GET_N;
          end
        end
        GET_N: begin
          if (flag == FLAG_START) begin
            wn_d = idx;
            if (wm == '0 || wm > IW'(MAX_ROWS) || idx == '0 || idx > IW'(MAX_COLS)) begin
              error_d = 1'b1;
              state_d = IDLE;
            end else begin
              row_d      = '0;
              col_d      = '0;
              row_base_d = '0;
              expected_d = '0;
              state_d    = ASSIGN;
            end
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
        ASSIGN: begin
          if (flag == FLAG_AND && idx == expected) begin
            wbits_d[cell_idx] = val;
            expected_d        = expected + IW'(1);
            if (IW'(col) < wn - IW'(1)) begin
              col_d = col + CW'(1);
            end else begin
              col_d      = '0;
              row_d      = row + RW'(1);
              row_base_d = row_base + BW'(MAX_COLS);
            end
            if (last_cell) state_d = WAIT_END;
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
        WAIT_END: begin
          if (flag == FLAG_END) begin
            board_d = wbits;
            m_d     = MW'(wm);
            n_d     = NW'(wn);
            valid_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_receiver.sv
// Directed bench for board_receiver: byte sequences with hand-computed results.
module tb_board_receiver;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [7:0]   byte_in;
  logic [120:0] board;
  logic [3:0]   m;
  logic [3:0]   n;
  logic         valid_out;
  logic         error;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int ecnt = 0;
  int both_cnt = 0;
  int v0, e0;

  logic [7:0] seq23 [18] = '{8'h04, 8'hE0, 8'h06, 8'hE0, 8'h01, 8'hA0, 8'h02, 8'hA0,
                             8'h05, 8'hA0, 8'h07, 8'hA0, 8'h09, 8'hA0, 8'h0A, 8'hA0,
                             8'h00, 8'h00};

  board_receiver #(.MAX_ROWS(11), .MAX_COLS(11)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .byte_in(byte_in),
    .board(board), .m(m), .n(n), .valid_out(valid_out), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters: values seen at posedge are those held through the previous cycle
  always @(posedge clk) begin
    if (valid_out) vcnt <= vcnt + 1;
    if (error) ecnt <= ecnt + 1;
    if (valid_out && error) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    valid_in = 1'b1;
    byte_in  = b;
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
    byte_in  = 8'h00;
  endtask

  task automatic send23();
    for (int i = 0; i < 18; i++) send(seq23[i]);
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    byte_in = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_board", 128'(board), 128'h0);
    chk("rst_m", 128'(m), 128'h0);
    chk("rst_n", 128'(n), 128'h0);
    chk("rst_valid", 128'(valid_out), 128'h0);
    chk("rst_error", 128'(error), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);

    // 2x3 board
    send(8'h04);
    send(8'hE0);
    send(8'h06);
    chk("busy_mid", 128'(busy), 128'h1);
    for (int i = 3; i < 18; i++) send(seq23[i]);
    idle();
    chk("b1_valid", 128'(valid_out), 128'h1);
    chk("b1_board", 128'(board), 128'h1805);
    chk("b1_m", 128'(m), 128'h2);
    chk("b1_n", 128'(n), 128'h3);
    chk("b1_error", 128'(error), 128'h0);
    chk("b1_busy", 128'(busy), 128'h0);
    idle();
    chk("b1_pulse_end", 128'(valid_out), 128'h0);
    chk("b1_vcnt", 128'(vcnt), 128'h1);
    chk("b1_ecnt", 128'(ecnt), 128'h0);

    // Index mismatch
    send(8'h04); send(8'hE0); send(8'h06); send(8'hE0); send(8'h02);
    send(8'hA0);
    idle();
    chk("mis_error", 128'(error), 128'h1);
    chk("mis_valid", 128'(valid_out), 128'h0);
    chk("mis_busy", 128'(busy), 128'h0);
    chk("mis_board", 128'(board), 128'h1805);
    chk("mis_m", 128'(m), 128'h2);
    chk("mis_n", 128'(n), 128'h3);
    idle();
    chk("mis_pulse_end", 128'(error), 128'h0);

    // Bad dimension n=0, then a good board
    v0 = vcnt;
    send(8'h04); send(8'hE0); send(8'h00); send(8'hE0);
    idle();
    chk("dim_error", 128'(error), 128'h1);
    chk("dim_valid", 128'(valid_out), 128'h0);
    send23();
    idle();
    chk("dim_next_valid", 128'(valid_out), 128'h1);
    chk("dim_next_board", 128'(board), 128'h1805);
    idle();
    chk("dim_vcnt", 128'(vcnt - v0), 128'h1);

    // Garbage words in IDLE
    v0 = vcnt; e0 = ecnt;
    send(8'h01); send(8'hA0); send(8'h00); send(8'h00);
    idle();
    chk("garb_error", 128'(error), 128'h0);
    send23();
    idle();
    chk("garb_board", 128'(board), 128'h1805);
    idle();
    chk("garb_vcnt", 128'(vcnt - v0), 128'h1);
    chk("garb_ecnt", 128'(ecnt - e0), 128'h0);

    // Reset mid-message with a pending low byte
    send(8'h04); send(8'hE0); send(8'h06); send(8'hE0); send(8'h01);
    @(negedge clk);
    valid_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstm_busy", 128'(busy), 128'h0);
    chk("rstm_board", 128'(board), 128'h0);
    chk("rstm_m", 128'(m), 128'h0);
    send23();
    idle();
    chk("rstm_valid", 128'(valid_out), 128'h1);
    chk("rstm_board2", 128'(board), 128'h1805);
    chk("rstm_n", 128'(n), 128'h3);

    // Back-to-back: 2x3 then 1x1 with no gap
    idle();
    v0 = vcnt;
    send23();
    send(8'h02);
    chk("b2b_first_valid", 128'(valid_out), 128'h1);
    chk("b2b_first_board", 128'(board), 128'h1805);
    send(8'hE0); send(8'h02); send(8'hE0); send(8'h01); send(8'hA0); send(8'h00); send(8'h00);
    idle();
    chk("b2b_second_valid", 128'(valid_out), 128'h1);
    chk("b2b_second_board", 128'(board), 128'h1);
    chk("b2b_second_m", 128'(m), 128'h1);
    chk("b2b_second_n", 128'(n), 128'h1);
    idle();
    chk("b2b_vcnt", 128'(vcnt - v0), 128'h2);

    // Non-END word after the last cell
    send(8'h02); send(8'hE0); send(8'h02); send(8'hE0); send(8'h00); send(8'hA0);
    send(8'h01); send(8'hA0);
    idle();
    chk("wend_error", 128'(error), 128'h1);
    chk("wend_board", 128'(board), 128'h1);

    idle();
    chk("never_both", 128'(both_cnt), 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
